// File: rtl/apb_master_queued.sv
// rtl/apb_master_queued.sv - queued APB3/APB4 master bridge with region decode and PREADY timeout
module apb_master_queued #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NO_SLAVES   = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 16,
  parameter int PROTOCOL_V4 = 1
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic                            Transfer,
  output logic                            PSI_READY,
  input  logic [ADDR_WIDTH-1:0]           PSI_ADDR,
  input  logic                            PSI_WRITE,
  input  logic [DATA_WIDTH-1:0]           PSI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]         PSI_STRB,
  input  logic [2:0]                      PSI_PROT,
  output logic                            PSO_VALID,
  output logic [DATA_WIDTH-1:0]           PSO_RDATA,
  output logic                            PSO_SLVERR,
  output logic                            PSO_TIMEOUT,
  output logic [ADDR_WIDTH-1:0]           PADDR,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  output logic                            PWRITE,
  output logic                            PENABLE,
  output logic [NO_SLAVES-1:0]            PSELx,
  output logic [DATA_WIDTH/8-1:0]         PSTRB,
  output logic [2:0]                      PPROT,
  input  logic [NO_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NO_SLAVES-1:0]            PREADY,
  input  logic [NO_SLAVES-1:0]            PSLVERR
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int SEL_BITS = (NO_SLAVES > 1) ? $clog2(NO_SLAVES) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ENTRY_W  = ADDR_WIDTH + 1 + DATA_WIDTH + STRB_W + 3;
  localparam int WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DERR} state_t;

  logic [ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  state_t                r_state;
  logic [WAIT_W-1:0]     r_wait;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_pwrite;
  logic                  r_penable;
  logic [NO_SLAVES-1:0]  r_psel;
  logic [STRB_W-1:0]     r_pstrb;
  logic [2:0]            r_pprot;
  logic                  r_pso_valid;
  logic [DATA_WIDTH-1:0] r_pso_rdata;
  logic                  r_pso_slverr;
  logic                  r_pso_timeout;

  logic                  w_push, w_pop, w_done, w_tmo_hit, w_derr;
  logic [ENTRY_W-1:0]    w_head;
  logic [ADDR_WIDTH-1:0] w_h_addr;
  logic                  w_h_write;
  logic [DATA_WIDTH-1:0] w_h_wdata;
  logic [STRB_W-1:0]     w_h_strb;
  logic [2:0]            w_h_prot;
  logic [SEL_BITS-1:0]   w_idx;
  logic [NO_SLAVES-1:0]  w_sel_oh;
  logic                  w_pready, w_pslverr;
  logic [DATA_WIDTH-1:0] w_prdata;

  assign PSI_READY = (r_count != FIFO_FULL);
  assign w_push    = Transfer && PSI_READY;

  always_ff @(posedge PCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= {PSI_ADDR, PSI_WRITE, PSI_WDATA, PSI_STRB, PSI_PROT};
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign w_head = r_mem[r_rd_ptr];
  assign {w_h_addr, w_h_write, w_h_wdata, w_h_strb, w_h_prot} = w_head;
  assign w_idx  = w_h_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_derr = (32'(w_idx) >= NO_SLAVES);

  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < NO_SLAVES; i++) w_sel_oh[i] = (32'(w_idx) == i);
  end

  // Only the currently selected completer is allowed to influence the response
  always_comb begin
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_prdata  = '0;
    for (int i = 0; i < NO_SLAVES; i++) begin
      if (r_psel[i]) begin
        w_pready  = PREADY[i];
        w_pslverr = PSLVERR[i];
        w_prdata  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_tmo_hit = (r_wait == WAIT_LAST);
  assign w_done    = (r_state == S_ACCESS) && (w_pready || w_tmo_hit);
  assign w_pop     = (r_count != '0) && ((r_state == S_IDLE) || w_done);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= S_IDLE;
      r_wait        <= '0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pwrite      <= 1'b0;
      r_penable     <= 1'b0;
      r_psel        <= '0;
      r_pstrb       <= '0;
      r_pprot       <= '0;
      r_pso_valid   <= 1'b0;
      r_pso_rdata   <= '0;
      r_pso_slverr  <= 1'b0;
      r_pso_timeout <= 1'b0;
    end else begin
      r_pso_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: ;
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_done) begin
            r_pso_valid   <= 1'b1;
            r_pso_slverr  <= w_pready ? w_pslverr : 1'b1;
            r_pso_timeout <= !w_pready;
            r_pso_rdata   <= (w_pready && !r_pwrite && !w_pslverr) ? w_prdata : '0;
            r_psel        <= '0;
            r_penable     <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DERR: begin
          r_pso_valid   <= 1'b1;
          r_pso_slverr  <= 1'b1;
          r_pso_timeout <= 1'b0;
          r_pso_rdata   <= '0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // A pop overrides the return to IDLE so queued work chains with no gap
      if (w_pop) begin
        r_paddr   <= w_h_addr;
        r_pwrite  <= w_h_write;
        r_pwdata  <= w_h_wdata;
        r_pstrb   <= w_h_write ? w_h_strb : '0;
        r_pprot   <= w_h_prot;
        r_psel    <= w_derr ? '0 : w_sel_oh;
        r_penable <= 1'b0;
        r_wait    <= '0;
        r_state   <= w_derr ? S_DERR : S_SETUP;
      end
    end
  end

  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign PWRITE      = r_pwrite;
  assign PENABLE     = r_penable;
  assign PSELx       = r_psel;
  assign PSTRB       = (PROTOCOL_V4 != 0) ? r_pstrb : '0;
  assign PPROT       = (PROTOCOL_V4 != 0) ? r_pprot : '0;
  assign PSO_VALID   = r_pso_valid;
  assign PSO_RDATA   = r_pso_rdata;
  assign PSO_SLVERR  = r_pso_slverr;
  assign PSO_TIMEOUT = r_pso_timeout;

endmodule

// File: tb/tb_apb_master_queued.sv
// tb/tb_apb_master_queued.sv - directed bench for apb_master_queued (4-slave and 3-slave instances)
module tb_apb_master_queued;

  logic PCLK, PRESETn;
  int total, bad;

  logic        a_transfer, a_ready, a_write, a_pso_valid, a_slverr, a_tmo, a_pwrite, a_penable;
  logic [31:0] a_addr, a_wdata, a_rdata, a_paddr, a_pwdata;
  logic [3:0]  a_strb, a_pstrb, a_psel, a_pready, a_pslverr;
  logic [2:0]  a_prot, a_pprot;
  logic [127:0] a_prdata;

  logic        b_transfer, b_ready, b_write, b_pso_valid, b_slverr, b_tmo, b_pwrite, b_penable;
  logic [31:0] b_addr, b_wdata, b_rdata, b_paddr, b_pwdata;
  logic [3:0]  b_strb, b_pstrb;
  logic [2:0]  b_psel, b_pready, b_pslverr;
  logic [2:0]  b_prot, b_pprot;
  logic [95:0] b_prdata;

  apb_master_queued #(.NO_SLAVES(4)) u_dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .Transfer(a_transfer), .PSI_READY(a_ready),
    .PSI_ADDR(a_addr), .PSI_WRITE(a_write), .PSI_WDATA(a_wdata), .PSI_STRB(a_strb), .PSI_PROT(a_prot),
    .PSO_VALID(a_pso_valid), .PSO_RDATA(a_rdata), .PSO_SLVERR(a_slverr), .PSO_TIMEOUT(a_tmo),
    .PADDR(a_paddr), .PWDATA(a_pwdata), .PWRITE(a_pwrite), .PENABLE(a_penable), .PSELx(a_psel),
    .PSTRB(a_pstrb), .PPROT(a_pprot), .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr)
  );

  apb_master_queued #(.NO_SLAVES(3)) u_dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .Transfer(b_transfer), .PSI_READY(b_ready),
    .PSI_ADDR(b_addr), .PSI_WRITE(b_write), .PSI_WDATA(b_wdata), .PSI_STRB(b_strb), .PSI_PROT(b_prot),
    .PSO_VALID(b_pso_valid), .PSO_RDATA(b_rdata), .PSO_SLVERR(b_slverr), .PSO_TIMEOUT(b_tmo),
    .PADDR(b_paddr), .PWDATA(b_pwdata), .PWRITE(b_pwrite), .PENABLE(b_penable), .PSELx(b_psel),
    .PSTRB(b_pstrb), .PPROT(b_pprot), .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic a_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr);
    a_transfer = 1'b1; a_addr = addr; a_write = wr; a_wdata = wd; a_strb = st; a_prot = pr;
  endtask

  task automatic b_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    b_transfer = 1'b1; b_addr = addr; b_write = wr; b_wdata = wd; b_strb = 4'hF; b_prot = 3'b000;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (a_psel !== 4'h0) begin bad++; $display("FAIL rst_psel got=%h exp=0", a_psel); end
    total++; if (a_penable !== 1'b0) begin bad++; $display("FAIL rst_penable got=%b exp=0", a_penable); end
    total++; if (a_pso_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", a_pso_valid); end
    total++; if (a_paddr !== 32'h0) begin bad++; $display("FAIL rst_paddr got=%h exp=0", a_paddr); end
    PRESETn = 1'b1;
    tick();
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", a_ready); end
    total++; if (b_psel !== 3'h0) begin bad++; $display("FAIL rst_b_psel got=%h exp=0", b_psel); end
  endtask

  task automatic test_single_write();
    a_pready = 4'hF; a_pslverr = 4'h0;
    a_req(32'h4000_0010, 1'b1, 32'hA5A5_0001, 4'hF, 3'b101);
    tick();
    a_transfer = 1'b0;
    tick();
    total++; if (a_psel !== 4'b0010) begin bad++; $display("FAIL wr_psel got=%h exp=2", a_psel); end
    total++; if (a_penable !== 1'b0) begin bad++; $display("FAIL wr_setup_en got=%b exp=0", a_penable); end
    total++; if (a_paddr !== 32'h4000_0010) begin bad++; $display("FAIL wr_paddr got=%h exp=40000010", a_paddr); end
    total++; if (a_pwdata !== 32'hA5A5_0001) begin bad++; $display("FAIL wr_pwdata got=%h exp=a5a50001", a_pwdata); end
    total++; if (a_pwrite !== 1'b1) begin bad++; $display("FAIL wr_pwrite got=%b exp=1", a_pwrite); end
    total++; if (a_pstrb !== 4'hF) begin bad++; $display("FAIL wr_pstrb got=%h exp=f", a_pstrb); end
    total++; if (a_pprot !== 3'b101) begin bad++; $display("FAIL wr_pprot got=%b exp=101", a_pprot); end
    tick();
    total++; if (a_penable !== 1'b1) begin bad++; $display("FAIL wr_access_en got=%b exp=1", a_penable); end
    total++; if (a_psel !== 4'b0010) begin bad++; $display("FAIL wr_access_psel got=%h exp=2", a_psel); end
    total++; if (a_pso_valid !== 1'b0) begin bad++; $display("FAIL wr_early_valid got=%b exp=0", a_pso_valid); end
    tick();
    total++; if (a_pso_valid !== 1'b1) begin bad++; $display("FAIL wr_valid got=%b exp=1", a_pso_valid); end
    total++; if (a_slverr !== 1'b0) begin bad++; $display("FAIL wr_slverr got=%b exp=0", a_slverr); end
    total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h exp=0", a_rdata); end
    total++; if ({a_psel, a_penable} !== 5'h0) begin bad++; $display("FAIL wr_idle got=%h exp=0", {a_psel, a_penable}); end
    tick();
    total++; if (a_pso_valid !== 1'b0) begin bad++; $display("FAIL wr_valid_pulse got=%b exp=0", a_pso_valid); end
  endtask

  task automatic test_wait_read();
    int en_cnt;
    en_cnt = 0;
    a_pready = 4'b0111;
    a_prdata = {32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333, 32'h1111_1111};
    a_req(32'hC000_0000, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b000);
    tick();
    a_transfer = 1'b0;
    tick();
    total++; if (a_psel !== 4'b1000) begin bad++; $display("FAIL rd_psel got=%h exp=8", a_psel); end
    total++; if (a_pstrb !== 4'h0) begin bad++; $display("FAIL rd_pstrb got=%h exp=0", a_pstrb); end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (a_penable) en_cnt++;
      if (c == 2) a_pready = 4'hF;
    end
    tick();
    total++; if (en_cnt !== 3) begin bad++; $display("FAIL rd_en_cycles got=%0d exp=3", en_cnt); end
    total++; if (a_pso_valid !== 1'b1) begin bad++; $display("FAIL rd_valid got=%b exp=1", a_pso_valid); end
    total++; if (a_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", a_rdata); end
    total++; if (a_slverr !== 1'b0) begin bad++; $display("FAIL rd_slverr got=%b exp=0", a_slverr); end
  endtask

  task automatic test_back_to_back();
    a_pready = 4'h0;
    for (int i = 0; i < 5; i++) begin
      a_req(32'h0000_0100 + 32'(i * 4), 1'b1, 32'h1000 + 32'(i), 4'hF, 3'b000);
      tick();
      total++; if (a_ready !== (i != 4)) begin bad++; $display("FAIL b2b_ready_%0d got=%b exp=%b", i, a_ready, i != 4); end
      if (i == 1) begin
        total++; if (a_paddr !== 32'h100) begin bad++; $display("FAIL b2b_first_addr got=%h exp=100", a_paddr); end
      end
    end
    a_req(32'h0000_0114, 1'b1, 32'h1005, 4'hF, 3'b000);
    a_pready = 4'hF;
    tick();
    a_transfer = 1'b0;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_drain got=%b exp=1", a_ready); end
    for (int j = 1; j < 5; j++) begin
      total++; if (a_pso_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_%0d got=%b exp=1", j, a_pso_valid); end
      total++; if (a_paddr !== 32'h100 + 32'(j * 4)) begin bad++; $display("FAIL b2b_addr_%0d got=%h exp=%h", j, a_paddr, 32'h100 + 32'(j * 4)); end
      total++; if (a_pwdata !== 32'h1000 + 32'(j)) begin bad++; $display("FAIL b2b_data_%0d got=%h exp=%h", j, a_pwdata, 32'h1000 + 32'(j)); end
      total++; if ({a_psel, a_penable} !== 5'b00010) begin bad++; $display("FAIL b2b_setup_%0d got=%b exp=00010", j, {a_psel, a_penable}); end
      tick();
      total++; if ({a_penable, a_pso_valid} !== 2'b10) begin bad++; $display("FAIL b2b_access_%0d got=%b exp=10", j, {a_penable, a_pso_valid}); end
      tick();
    end
    total++; if (a_pso_valid !== 1'b1) begin bad++; $display("FAIL b2b_last_valid got=%b exp=1", a_pso_valid); end
    total++; if (a_psel !== 4'h0) begin bad++; $display("FAIL b2b_last_psel got=%h exp=0", a_psel); end
    tick();
    total++; if ({a_psel, a_pso_valid} !== 5'h0) begin bad++; $display("FAIL b2b_dropped got=%b exp=0", {a_psel, a_pso_valid}); end
  endtask

  task automatic test_timeout();
    int en_cnt, early;
    en_cnt = 0; early = 0;
    a_pready = 4'b1011;
    a_req(32'h8000_0000, 1'b1, 32'hCAFE_0000, 4'hF, 3'b000);
    tick();
    a_req(32'h0000_0020, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    a_transfer = 1'b0;
    total++; if (a_psel !== 4'b0100) begin bad++; $display("FAIL tmo_psel got=%h exp=4", a_psel); end
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (a_penable) en_cnt++;
      if (a_pso_valid) early++;
    end
    tick();
    total++; if (en_cnt !== 16) begin bad++; $display("FAIL tmo_en_cycles got=%0d exp=16", en_cnt); end
    total++; if (early !== 0) begin bad++; $display("FAIL tmo_early_valid got=%0d exp=0", early); end
    total++; if ({a_pso_valid, a_slverr, a_tmo} !== 3'b111) begin bad++; $display("FAIL tmo_resp got=%b exp=111", {a_pso_valid, a_slverr, a_tmo}); end
    total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL tmo_rdata got=%h exp=0", a_rdata); end
    total++; if ({a_psel, a_penable} !== 5'b00010) begin bad++; $display("FAIL tmo_next_setup got=%b exp=00010", {a_psel, a_penable}); end
    total++; if (a_paddr !== 32'h20) begin bad++; $display("FAIL tmo_next_addr got=%h exp=20", a_paddr); end
    tick();
    tick();
    total++; if ({a_pso_valid, a_slverr, a_tmo} !== 3'b100) begin bad++; $display("FAIL tmo_next_resp got=%b exp=100", {a_pso_valid, a_slverr, a_tmo}); end
    total++; if (a_rdata !== 32'h1111_1111) begin bad++; $display("FAIL tmo_next_rdata got=%h exp=11111111", a_rdata); end
  endtask

  task automatic test_timeout_edge();
    a_pready = 4'b1011;
    a_req(32'h8000_0040, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    a_transfer = 1'b0;
    tick();
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 16) a_pready = 4'hF;
    end
    tick();
    total++; if ({a_pso_valid, a_slverr, a_tmo} !== 3'b100) begin bad++; $display("FAIL tedge_resp got=%b exp=100", {a_pso_valid, a_slverr, a_tmo}); end
    total++; if (a_rdata !== 32'h2222_2222) begin bad++; $display("FAIL tedge_rdata got=%h exp=22222222", a_rdata); end
  endtask

  task automatic test_reset_mid();
    int vcnt, scnt;
    vcnt = 0; scnt = 0;
    a_pready = 4'h0;
    for (int i = 0; i < 3; i++) begin
      a_req(32'h0000_0200 + 32'(i * 4), 1'b1, 32'h77 + 32'(i), 4'hF, 3'b000);
      tick();
    end
    a_transfer = 1'b0;
    total++; if (a_penable !== 1'b1) begin bad++; $display("FAIL rmid_pre_en got=%b exp=1", a_penable); end
    #2;
    PRESETn = 1'b0;
    #1;
    total++; if ({a_psel, a_penable} !== 5'h0) begin bad++; $display("FAIL rmid_sel got=%b exp=0", {a_psel, a_penable}); end
    total++; if (a_paddr !== 32'h0) begin bad++; $display("FAIL rmid_paddr got=%h exp=0", a_paddr); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", a_ready); end
    tick(); tick();
    PRESETn = 1'b1;
    a_pready = 4'hF;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (a_pso_valid) vcnt++;
      if (a_psel != 4'h0) scnt++;
    end
    total++; if (vcnt !== 0) begin bad++; $display("FAIL rmid_valid got=%0d exp=0", vcnt); end
    total++; if (scnt !== 0) begin bad++; $display("FAIL rmid_psel got=%0d exp=0", scnt); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_post got=%b exp=1", a_ready); end
  endtask

  task automatic test_decode_err();
    b_pready = 3'b111; b_pslverr = 3'b000;
    b_req(32'hC000_0000, 1'b0, 32'h0);
    tick();
    b_transfer = 1'b0;
    tick();
    total++; if ({b_psel, b_penable, b_pso_valid} !== 5'h0) begin bad++; $display("FAIL derr_pop got=%b exp=0", {b_psel, b_penable, b_pso_valid}); end
    tick();
    total++; if ({b_pso_valid, b_slverr, b_tmo} !== 3'b110) begin bad++; $display("FAIL derr_resp got=%b exp=110", {b_pso_valid, b_slverr, b_tmo}); end
    total++; if (b_rdata !== 32'h0) begin bad++; $display("FAIL derr_rdata got=%h exp=0", b_rdata); end
    total++; if (b_psel !== 3'h0) begin bad++; $display("FAIL derr_psel got=%h exp=0", b_psel); end
    tick();
    total++; if (b_pso_valid !== 1'b0) begin bad++; $display("FAIL derr_pulse got=%b exp=0", b_pso_valid); end
  endtask

  task automatic test_pslverr();
    b_pready = 3'b111; b_pslverr = 3'b100;
    b_prdata = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333};
    b_req(32'h8000_0000, 1'b0, 32'h0);
    tick();
    b_transfer = 1'b0;
    tick();
    total++; if (b_psel !== 3'b100) begin bad++; $display("FAIL serr_psel got=%b exp=100", b_psel); end
    tick();
    tick();
    total++; if ({b_pso_valid, b_slverr, b_tmo} !== 3'b110) begin bad++; $display("FAIL serr_resp got=%b exp=110", {b_pso_valid, b_slverr, b_tmo}); end
    total++; if (b_rdata !== 32'h0) begin bad++; $display("FAIL serr_rdata got=%h exp=0", b_rdata); end
    b_pslverr = 3'b000;
  endtask

  initial begin
    total = 0; bad = 0;
    PRESETn = 1'b0;
    a_transfer = 1'b0; a_addr = '0; a_write = 1'b0; a_wdata = '0; a_strb = '0; a_prot = '0;
    a_prdata = '0; a_pready = '0; a_pslverr = '0;
    b_transfer = 1'b0; b_addr = '0; b_write = 1'b0; b_wdata = '0; b_strb = '0; b_prot = '0;
    b_prdata = '0; b_pready = '0; b_pslverr = '0;
    test_reset();
    test_single_write();
    test_wait_read();
    test_back_to_back();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_decode_err();
    test_pslverr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
